ex_muldiv: RTL

Parametrised execute stage for the RISC-V core that replaces the purely combinational EX unit. It executes RV32I ALU, branch, JAL/JALR, LUI and AUIPC operations in one cycle, as before. It adds the RV32M multiply/divide instructions as multi-cycle operations and is the first EX unit to drive `hold_flag_o`. It sits between `id_ex` and the register file / `ctrl`.

---
 rtl/ex_muldiv_pkg.sv | 51 +++++
 rtl/ex_div.sv | 87 ++++++++
 rtl/ex_muldiv.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/ex_muldiv_pkg.sv
// Shared constants for the execute stage: opcodes, func3 codes, the M-extension
// func7 marker and the multiply/divide FSM state encoding.
package ex_muldiv_pkg;

    localparam logic [6:0] INST_TYPE_I   = 7'b0010011;
    localparam logic [6:0] INST_TYPE_R_M = 7'b0110011;
    localparam logic [6:0] INST_TYPE_B   = 7'b1100011;
    localparam logic [6:0] INST_JAL      = 7'b1101111;
    localparam logic [6:0] INST_JALR     = 7'b1100111;
    localparam logic [6:0] INST_LUI      = 7'b0110111;
    localparam logic [6:0] INST_AUIPC    = 7'b0010111;

    localparam logic [6:0] FUNC7_M = 7'b0000001;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [2:0] INST_BEQ  = 3'b000;
    localparam logic [2:0] INST_BNE  = 3'b001;
    localparam logic [2:0] INST_BLT  = 3'b100;
    localparam logic [2:0] INST_BGE  = 3'b101;
    localparam logic [2:0] INST_BLTU = 3'b110;
    localparam logic [2:0] INST_BGEU = 3'b111;

    localparam logic [2:0] INST_MUL    = 3'b000;
    localparam logic [2:0] INST_MULH   = 3'b001;
    localparam logic [2:0] INST_MULHSU = 3'b010;
    localparam logic [2:0] INST_MULHU  = 3'b011;
    localparam logic [2:0] INST_DIV    = 3'b100;
    localparam logic [2:0] INST_DIVU   = 3'b101;
    localparam logic [2:0] INST_REM    = 3'b110;
    localparam logic [2:0] INST_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    function automatic logic is_m_op(input logic [31:0] inst);
        return (inst[6:0] == INST_TYPE_R_M) && (inst[31:25] == FUNC7_M);
    endfunction

endpackage

// File: rtl/ex_div.sv
// Iterative radix-2 restoring divider on operand magnitudes, one quotient bit per
// cycle, with sign correction and combinational detection of the corner cases.
module ex_div #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            abort,
    input  logic            is_signed,
    input  logic            is_rem,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            busy,
    output logic            done,
    output logic            corner,
    output logic [XLEN-1:0] result
);
    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

    logic            busy_reg, neg_q_reg, neg_r_reg, rem_sel_reg;
    logic [CW-1:0]   count_reg;
    logic [XLEN-1:0] quot_reg, rem_reg, dsr_reg;

    logic            neg_a, neg_b, div_zero, overflow, fits;
    logic [XLEN:0]   trial, diff;
    logic [XLEN-1:0] quot_next, rem_next, q_fix, r_fix, corner_val;

    assign neg_a    = is_signed & dividend[XLEN-1];
    assign neg_b    = is_signed & divisor[XLEN-1];
    assign div_zero = (divisor == '0);
    assign overflow = is_signed && (dividend == MIN_VAL) && (divisor == '1);
    assign corner   = div_zero | overflow;

    // Shift the next dividend bit into the partial remainder and try to subtract.
    assign trial     = {rem_reg, quot_reg[XLEN-1]};
    assign diff      = trial - {1'b0, dsr_reg};
    assign fits      = ~diff[XLEN];
    assign rem_next  = fits ? diff[XLEN-1:0] : trial[XLEN-1:0];
    assign quot_next = {quot_reg[XLEN-2:0], fits};
    assign q_fix     = neg_q_reg ? -quot_next : quot_next;
    assign r_fix     = neg_r_reg ? -rem_next : rem_next;

    always_comb begin
        corner_val = '0;
        if (div_zero)
            corner_val = is_rem ? dividend : '1;
        else if (overflow)
            corner_val = is_rem ? '0 : dividend;
    end

    assign busy   = busy_reg;
    assign done   = busy_reg && (count_reg == '0);
    assign result = corner ? corner_val : (rem_sel_reg ? r_fix : q_fix);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_reg    <= 1'b0;
            neg_q_reg   <= 1'b0;
            neg_r_reg   <= 1'b0;
            rem_sel_reg <= 1'b0;
            count_reg   <= '0;
            quot_reg    <= '0;
            rem_reg     <= '0;
            dsr_reg     <= '0;
        end else if (abort) begin
            busy_reg <= 1'b0;
        end else if (start) begin
            busy_reg    <= 1'b1;
            count_reg   <= CW'(XLEN - 1);
            quot_reg    <= neg_a ? -dividend : dividend;
            dsr_reg     <= neg_b ? -divisor : divisor;
            rem_reg     <= '0;
            neg_q_reg   <= neg_a ^ neg_b;
            neg_r_reg   <= neg_a;
            rem_sel_reg <= is_rem;
        end else if (busy_reg) begin
            quot_reg  <= quot_next;
            rem_reg   <= rem_next;
            count_reg <= count_reg - 1'b1;
            if (count_reg == '0)
                busy_reg <= 1'b0;
        end
    end

endmodule

// File: rtl/ex_muldiv.sv
// Execute stage: single-cycle RV32I ALU/branch/jump path plus multi-cycle RV32M
// multiply/divide sequenced by a small FSM that stalls the pipeline via hold_flag_o.
module ex_muldiv
    import ex_muldiv_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       inst_i,
    input  logic [XLEN-1:0]   inst_addr_i,
    input  logic [XLEN-1:0]   op1_i,
    input  logic [XLEN-1:0]   op2_i,
    input  logic [REG_AW-1:0] rd_addr_i,
    input  logic              rd_wen_i,
    input  logic [XLEN-1:0]   base_addr_i,
    input  logic [XLEN-1:0]   addr_offset_i,
    input  logic              flush_i,
    output logic [REG_AW-1:0] rd_addr_o,
    output logic [XLEN-1:0]   rd_data_o,
    output logic              rd_wen_o,
    output logic [XLEN-1:0]   jump_addr_o,
    output logic              jump_en_o,
    output logic              hold_flag_o
);
    localparam int SHW = $clog2(XLEN);

    logic [6:0]      opcode;
    logic [2:0]      func3, f3_sel;
    logic            m_op, lt_s, lt_u, sub_sel;
    logic [SHW-1:0]  shamt;
    logic [XLEN-1:0] sra_val;
    logic            unused_bits;

    assign opcode  = inst_i[6:0];
    assign func3   = inst_i[14:12];
    assign m_op    = is_m_op(inst_i);
    assign shamt   = op2_i[SHW-1:0];
    assign lt_s    = $signed(op1_i) < $signed(op2_i);
    assign lt_u    = op1_i < op2_i;
    assign sra_val = $signed(op1_i) >>> shamt;
    assign sub_sel = (opcode == INST_TYPE_R_M) && inst_i[30];
    // ID already folds the PC into op1 for AUIPC, so the raw PC is not needed here.
    assign unused_bits = ^{inst_i[24:15], inst_i[11:7], inst_addr_i};

    state_t            state_reg;
    logic [XLEN-1:0]   op1_reg, op2_reg, result_reg;
    logic [2*XLEN-1:0] prod_reg;
    logic [2:0]        func3_reg;
    logic [REG_AW-1:0] rd_reg;

    // Multiplier: sign-extend each operand to 2*XLEN so one product covers all variants.
    logic              mul_a_signed, mul_b_signed;
    logic [2*XLEN-1:0] mul_a_ext, mul_b_ext, mul_product;

    assign mul_a_signed = (func3_reg == INST_MUL) || (func3_reg == INST_MULH) || (func3_reg == INST_MULHSU);
    assign mul_b_signed = (func3_reg == INST_MUL) || (func3_reg == INST_MULH);
    assign mul_a_ext    = {{XLEN{mul_a_signed & op1_reg[XLEN-1]}}, op1_reg};
    assign mul_b_ext    = {{XLEN{mul_b_signed & op2_reg[XLEN-1]}}, op2_reg};
    assign mul_product  = mul_a_ext * mul_b_ext;

    // In IDLE the divider sees live operands so corner cases resolve in the issue cycle.
    logic            is_div, div_start, div_busy, div_done, div_corner;
    logic [XLEN-1:0] div_result;

    assign f3_sel    = (state_reg == ST_IDLE) ? func3 : func3_reg;
    assign is_div    = (func3 == INST_DIV) || (func3 == INST_DIVU) || (func3 == INST_REM) || (func3 == INST_REMU);
    assign div_start = (state_reg == ST_DIV) && !div_busy && !flush_i;

    ex_div #(.XLEN(XLEN)) u_div (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (div_start),
        .abort     (flush_i),
        .is_signed ((f3_sel == INST_DIV) || (f3_sel == INST_REM)),
        .is_rem    ((f3_sel == INST_REM) || (f3_sel == INST_REMU)),
        .dividend  ((state_reg == ST_IDLE) ? op1_i : op1_reg),
        .divisor   ((state_reg == ST_IDLE) ? op2_i : op2_reg),
        .busy      (div_busy),
        .done      (div_done),
        .corner    (div_corner),
        .result    (div_result)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= ST_IDLE;
            op1_reg    <= '0;
            op2_reg    <= '0;
            func3_reg  <= '0;
            rd_reg     <= '0;
            prod_reg   <= '0;
            result_reg <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: if (m_op && !flush_i) begin
                    op1_reg   <= op1_i;
                    op2_reg   <= op2_i;
                    func3_reg <= func3;
                    rd_reg    <= rd_addr_i;
                    if (!is_div) begin
                        state_reg <= ST_MUL;
                    end else if (div_corner) begin
                        result_reg <= div_result;
                        state_reg  <= ST_DONE;
                    end else begin
                        state_reg <= ST_DIV;
                    end
                end
                ST_MUL: if (flush_i) begin
                    state_reg <= ST_IDLE;
                end else begin
                    prod_reg  <= mul_product;
                    state_reg <= ST_DONE;
                end
                ST_DIV: if (flush_i) begin
                    state_reg <= ST_IDLE;
                end else if (div_done) begin
                    result_reg <= div_result;
                    state_reg  <= ST_DONE;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    // Single-cycle path for everything that is not an M-op.
    logic [XLEN-1:0] alu_data;
    logic            alu_wen, alu_jump;

    always_comb begin
        alu_data = '0;
        alu_wen  = 1'b0;
        alu_jump = 1'b0;
        case (opcode)
            INST_TYPE_I, INST_TYPE_R_M: if (!m_op) begin
                alu_wen = rd_wen_i;
                case (func3)
                    F3_ADD:  alu_data = sub_sel ? op1_i - op2_i : op1_i + op2_i;
                    F3_SLL:  alu_data = op1_i << shamt;
                    F3_SLT:  alu_data = {{(XLEN-1){1'b0}}, lt_s};
                    F3_SLTU: alu_data = {{(XLEN-1){1'b0}}, lt_u};
                    F3_XOR:  alu_data = op1_i ^ op2_i;
                    F3_SR:   alu_data = inst_i[30] ? sra_val : op1_i >> shamt;
                    F3_OR:   alu_data = op1_i | op2_i;
                    F3_AND:  alu_data = op1_i & op2_i;
                    default: alu_data = '0;
                endcase
            end
            INST_TYPE_B: begin
                case (func3)
                    INST_BEQ:  alu_jump = (op1_i == op2_i);
                    INST_BNE:  alu_jump = (op1_i != op2_i);
                    INST_BLT:  alu_jump = lt_s;
                    INST_BGE:  alu_jump = !lt_s;
                    INST_BLTU: alu_jump = lt_u;
                    INST_BGEU: alu_jump = !lt_u;
                    default:   alu_jump = 1'b0;
                endcase
            end
            INST_JAL, INST_JALR: begin
                alu_wen  = rd_wen_i;
                alu_data = op1_i + op2_i;
                alu_jump = 1'b1;
            end
            INST_LUI, INST_AUIPC: begin
                alu_wen  = rd_wen_i;
                alu_data = op1_i + op2_i;
            end
            default: ;
        endcase
    end

    logic [XLEN-1:0] done_data;

    always_comb begin
        case (func3_reg)
            INST_MUL:                          done_data = prod_reg[XLEN-1:0];
            INST_MULH, INST_MULHSU, INST_MULHU: done_data = prod_reg[2*XLEN-1:XLEN];
            default:                           done_data = result_reg;
        endcase
    end

    always_comb begin
        rd_addr_o   = '0;
        rd_data_o   = '0;
        rd_wen_o    = 1'b0;
        jump_addr_o = '0;
        jump_en_o   = 1'b0;
        hold_flag_o = 1'b0;
        if (rst_n) begin
            case (state_reg)
                ST_IDLE: if (m_op) begin
                    hold_flag_o = !flush_i;
                end else begin
                    rd_wen_o    = alu_wen;
                    rd_addr_o   = alu_wen ? rd_addr_i : '0;
                    rd_data_o   = alu_data;
                    jump_en_o   = alu_jump;
                    jump_addr_o = alu_jump ? base_addr_i + addr_offset_i : '0;
                end
                ST_MUL, ST_DIV: hold_flag_o = 1'b1;
                default: if (!flush_i) begin
                    rd_wen_o  = 1'b1;
                    rd_addr_o = rd_reg;
                    rd_data_o = done_data;
                end
            endcase
        end
    end

endmodule
